// File: rtl/io_input_pkg.sv
// Shared definitions for the io_input CPU input port: register offsets
// within the 8-byte window, used by the top-level address decode.
package io_input_pkg;

  localparam logic [2:0] IO_IN_PIN   = 3'd0;
  localparam logic [2:0] IO_IN_EVT   = 3'd1;
  localparam logic [2:0] IO_IN_RISE  = 3'd2;
  localparam logic [2:0] IO_IN_FALL  = 3'd3;
  localparam logic [2:0] IO_IN_IRQEN = 3'd4;

endpackage

// File: rtl/io_input_if.sv
// CPU bus slice seen by io_input: next-cycle address, write data/strobe
// and the registered read data that gets ORed into cpu_data_in.
interface io_input_if;

  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        write_enable;
  logic [7:0]  data_out;

  modport master (
    output addr,
    output data_in,
    output write_enable,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  write_enable,
    output data_out
  );

endinterface

// File: rtl/io_input_debounce_bit.sv
// One input pin: 2-flop synchroniser followed by a mismatch counter that
// only moves the stable level after DEBOUNCE_CYCLES consecutive mismatches.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic cpu_clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          update;

  assign sync   = sync_q[1];
  assign update = (sync != stable) && (cnt == CNT_LAST);

  // Pulses coincide with the edge that moves stable, so the event register
  // latches on the same edge.
  assign rise_pulse = update & sync;
  assign fall_pulse = update & ~sync;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], pin};
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input.sv
// CPU-readable input port: debounced pin levels, sticky edge events with
// write-1-to-clear, and a registered level IRQ toward the bc6502.
module io_input
  import io_input_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'hC010,
  parameter int          WIDTH           = 8,
  parameter int          DEBOUNCE_CYCLES = 4096
) (
  input  logic             cpu_clk,
  input  logic             reset,
  io_input_if.slave        bus,
  input  logic [WIDTH-1:0] pins_in,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] evt_clr;
  logic             irq_en;
  logic             sel;
  logic             wr;
  logic [2:0]       offset;
  logic [7:0]       rd_data;

  assign sel    = (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign offset = bus.addr[2:0];
  assign wr     = sel & bus.write_enable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .cpu_clk   (cpu_clk),
      .reset     (reset),
      .pin       (pins_in[i]),
      .stable    (stable[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  function automatic logic [7:0] pad8(input logic [WIDTH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  always_comb begin
    rd_data = '0;
    case (offset)
      IO_IN_PIN:   rd_data = pad8(stable);
      IO_IN_EVT:   rd_data = pad8(evt);
      IO_IN_RISE:  rd_data = pad8(rise_en);
      IO_IN_FALL:  rd_data = pad8(fall_en);
      IO_IN_IRQEN: rd_data = {7'b0, irq_en};
      default:     rd_data = '0;
    endcase
  end

  assign evt_clr = (wr && offset == IO_IN_EVT) ? bus.data_in[WIDTH-1:0] : '0;

  // New events are ORed in after the clear so a same-edge set beats W1C.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      evt          <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      bus.data_out <= '0;
    end else begin
      evt <= (evt & ~evt_clr) | (rise_pulse & rise_en) | (fall_pulse & fall_en);
      if (wr) begin
        case (offset)
          IO_IN_RISE:  rise_en <= bus.data_in[WIDTH-1:0];
          IO_IN_FALL:  fall_en <= bus.data_in[WIDTH-1:0];
          IO_IN_IRQEN: irq_en  <= bus.data_in[0];
          default:     ;
        endcase
      end
      irq          <= irq_en & (|evt);
      bus.data_out <= sel ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_io_input.sv
// Bench for io_input with DEBOUNCE_CYCLES=4: a window-based behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_io_input;

  localparam int D = 4;
  localparam logic [15:0] BASE = 16'hC010;

  logic       cpu_clk;
  logic       reset;
  logic [7:0] pins_in;
  logic       irq;

  io_input_if bus_if ();

  io_input #(
    .BASE_ADDR      (BASE),
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .cpu_clk(cpu_clk),
    .reset  (reset),
    .bus    (bus_if),
    .pins_in(pins_in),
    .irq    (irq)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Behavioural model: a pin's stable level flips once the last D synchronised
  // samples (raw samples two edges old and older) all disagree with it.
  logic [7:0] hist [0:D];
  logic [7:0] m_stable = '0, m_evt = '0, m_rise = '0, m_fall = '0;
  logic       m_irqen = 1'b0;
  logic [7:0] m_dout = '0;
  logic       m_irq = 1'b0;
  logic [7:0] n_stable, r_ev, f_ev, clr, rd;
  logic       m_sel, mism;

  always @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      m_stable = '0; m_evt = '0; m_rise = '0; m_fall = '0;
      m_irqen = 1'b0; m_dout = '0; m_irq = 1'b0;
      for (int j = 0; j <= D; j++) hist[j] = '0;
    end else begin
      n_stable = m_stable;
      for (int i = 0; i < 8; i++) begin
        mism = 1'b1;
        for (int j = 1; j <= D; j++)
          if (hist[j][i] == m_stable[i]) mism = 1'b0;
        if (mism) n_stable[i] = ~m_stable[i];
      end
      r_ev = n_stable & ~m_stable;
      f_ev = ~n_stable & m_stable;
      m_sel = (bus_if.addr[15:3] == BASE[15:3]);
      case (bus_if.addr[2:0])
        3'd0: rd = m_stable;
        3'd1: rd = m_evt;
        3'd2: rd = m_rise;
        3'd3: rd = m_fall;
        3'd4: rd = {7'b0, m_irqen};
        default: rd = 8'h00;
      endcase
      m_dout = m_sel ? rd : 8'h00;
      m_irq  = m_irqen & (|m_evt);
      clr = (m_sel && bus_if.write_enable && bus_if.addr[2:0] == 3'd1) ? bus_if.data_in : 8'h00;
      m_evt = (m_evt & ~clr) | (r_ev & m_rise) | (f_ev & m_fall);
      if (m_sel && bus_if.write_enable) begin
        if (bus_if.addr[2:0] == 3'd2) m_rise = bus_if.data_in;
        if (bus_if.addr[2:0] == 3'd3) m_fall = bus_if.data_in;
        if (bus_if.addr[2:0] == 3'd4) m_irqen = bus_if.data_in[0];
      end
      m_stable = n_stable;
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = pins_in;
    end
  end

  always @(negedge cpu_clk) begin
    tests_run++;
    if (bus_if.data_out !== m_dout || irq !== m_irq) begin
      tests_failed++;
      $display("FAIL model_cmp t=%0t data_out=%h exp=%h irq=%b exp=%b",
               $time, bus_if.data_out, m_dout, irq, m_irq);
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr = a; bus_if.data_in = d; bus_if.write_enable = 1'b1;
    tick();
    bus_if.write_enable = 1'b0; bus_if.data_in = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_if.addr = a;
    tick();
    check(name, bus_if.data_out, exp);
  endtask

  initial begin
    bus_if.addr = 16'h0000; bus_if.data_in = 8'h00; bus_if.write_enable = 1'b0;
    pins_in = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    ticks(2);
    reset = 1'b0;

    // 1: reset values across the window, writes to 5..7 ignored
    for (int a = 0; a < 8; a++) rd_chk("reset_read", BASE + 16'(a), 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    wr(16'hC015, 8'hFF);
    rd_chk("reg5_ignored", 16'hC015, 8'h00);
    wr(16'hC010, 8'hFF);
    rd_chk("pin_write_ignored", 16'hC010, 8'h00);

    // 2: debounce latency on pin0
    bus_if.addr = 16'hC010;
    pins_in[0] = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 5) check("pin0_not_early", bus_if.data_out, 8'h00);
      if (j == 6) check("pin0_latency", bus_if.data_out, 8'h01);
    end
    rd_chk("unselected", 16'h8000, 8'h00);

    // 3: glitch rejection and minimal accepted pulse on pin1
    bus_if.addr = 16'hC010;
    pins_in[1] = 1'b1; ticks(3); pins_in[1] = 1'b0;
    ticks(8);
    check("glitch_rejected", bus_if.data_out, 8'h01);
    rd_chk("glitch_no_evt", 16'hC011, 8'h00);
    bus_if.addr = 16'hC010;
    pins_in[1] = 1'b1; ticks(4); pins_in[1] = 1'b0;
    ticks(3);
    check("pulse4_accepted", bus_if.data_out, 8'h03);
    ticks(7);
    check("pulse4_returns", bus_if.data_out, 8'h01);

    // 4: rise event, irq, W1C
    pins_in[0] = 1'b0; ticks(8);
    wr(16'hC012, 8'h01);
    wr(16'hC014, 8'h01);
    bus_if.addr = 16'hC011;
    pins_in[0] = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 5) begin
        check("rise_evt_not_early", bus_if.data_out, 8'h00);
        check("irq_not_early", {7'b0, irq}, 8'h00);
      end
      if (j == 6) begin
        check("rise_evt", bus_if.data_out, 8'h01);
        check("irq_set", {7'b0, irq}, 8'h01);
      end
    end
    wr(16'hC011, 8'h01);
    check("irq_trails_clear", {7'b0, irq}, 8'h01);
    tick();
    check("evt_cleared", bus_if.data_out, 8'h00);
    check("irq_cleared", {7'b0, irq}, 8'h00);

    // 5: fall-only enable on pin2, set beats W1C
    wr(16'hC012, 8'h00);
    wr(16'hC013, 8'h04);
    bus_if.addr = 16'hC011;
    pins_in[2] = 1'b1; ticks(8);
    check("no_rise_evt", bus_if.data_out, 8'h00);
    pins_in[2] = 1'b0; ticks(7);
    check("fall_evt", bus_if.data_out, 8'h04);
    pins_in[2] = 1'b1; ticks(8);
    pins_in[2] = 1'b0; ticks(5);
    wr(16'hC011, 8'h04);
    tick();
    check("set_beats_w1c", bus_if.data_out, 8'h04);
    wr(16'hC011, 8'h04);
    tick();
    check("w1c_bit2", bus_if.data_out, 8'h00);

    // 6: reset mid-debounce
    wr(16'hC012, 8'h01);
    wr(16'hC013, 8'h01);
    bus_if.addr = 16'hC011;
    pins_in[0] = 1'b0; ticks(7);
    check("fall0_irq", {7'b0, irq}, 8'h01);
    pins_in[0] = 1'b1; ticks(4);
    reset = 1'b1;
    #1;
    check("async_irq_drop", {7'b0, irq}, 8'h00);
    check("async_dout_drop", bus_if.data_out, 8'h00);
    ticks(2);
    reset = 1'b0;
    bus_if.addr = 16'hC010;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 6) check("post_reset_not_early", bus_if.data_out, 8'h00);
      if (j == 7) check("post_reset_pin0", bus_if.data_out, 8'h01);
    end
    rd_chk("post_reset_evt", 16'hC011, 8'h00);
    rd_chk("post_reset_rise", 16'hC012, 8'h00);
    rd_chk("post_reset_fall", 16'hC013, 8'h00);
    rd_chk("post_reset_irqen", 16'hC014, 8'h00);
    check("post_reset_irq", {7'b0, irq}, 8'h00);

    ticks(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
